// File: rtl/sequence_checker.sv
// Frame-alignment checker for the repeating 4-word pattern 0011,0110,0001,0100.
// Hunts for the sync word, tracks alignment, declares lock after LOCK_FRAMES clean frames.
module sequence_checker #(
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_valid,
  input  logic [3:0]       seq_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             frame_done,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [3:0]       SYNC_WORD = 4'b0011;
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_reg, state_next;
  logic [1:0]       exp_idx_reg, exp_idx_next;
  logic [3:0]       good_reg, good_next;
  logic             locked_reg, locked_next;
  logic             frame_done_reg, frame_done_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic             frame_inc, err_inc;

  function automatic logic [3:0] frame_word(input logic [1:0] idx);
    case (idx)
      2'd0:    frame_word = 4'b0011;
      2'd1:    frame_word = 4'b0110;
      2'd2:    frame_word = 4'b0001;
      default: frame_word = 4'b0100;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= HUNT;
      exp_idx_reg    <= 2'd0;
      good_reg       <= 4'd0;
      locked_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      err_reg        <= 1'b0;
      frame_cnt_reg  <= '0;
      err_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      exp_idx_reg    <= exp_idx_next;
      good_reg       <= good_next;
      locked_reg     <= locked_next;
      frame_done_reg <= frame_done_next;
      err_reg        <= err_next;
      frame_cnt_reg  <= frame_cnt_next;
      err_cnt_reg    <= err_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    exp_idx_next    = exp_idx_reg;
    good_next       = good_reg;
    locked_next     = locked_reg;
    frame_done_next = 1'b0;
    err_next        = 1'b0;
    frame_inc       = 1'b0;
    err_inc         = 1'b0;

    if (seq_valid) begin
      case (state_reg)
        HUNT: begin
          if (seq_in == SYNC_WORD) begin
            state_next   = TRACK;
            exp_idx_next = 2'd1;
          end
        end
        TRACK: begin
          if (seq_in == frame_word(exp_idx_reg)) begin
            exp_idx_next = exp_idx_reg + 2'd1;
            if (exp_idx_reg == 2'd3) begin
              frame_done_next = 1'b1;
              frame_inc       = 1'b1;
              good_next       = (good_reg >= LOCK_N) ? LOCK_N : good_reg + 4'd1;
              if (good_next == LOCK_N)
                locked_next = 1'b1;
            end
          end else begin
            err_next    = 1'b1;
            err_inc     = 1'b1;
            good_next   = 4'd0;
            locked_next = 1'b0;
            // A stray sync word is taken as the start of a new frame.
            if (seq_in == SYNC_WORD) begin
              exp_idx_next = 2'd1;
            end else begin
              state_next   = HUNT;
              exp_idx_next = 2'd0;
            end
          end
        end
        default: begin
          state_next   = HUNT;
          exp_idx_next = 2'd0;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    if (clr_cnt) begin
      frame_cnt_next = '0;
      err_cnt_next   = '0;
    end else begin
      frame_cnt_next = (frame_inc && frame_cnt_reg != CNT_MAX) ? frame_cnt_reg + 1'b1 : frame_cnt_reg;
      err_cnt_next   = (err_inc && err_cnt_reg != CNT_MAX) ? err_cnt_reg + 1'b1 : err_cnt_reg;
    end
  end

  assign locked     = locked_reg;
  assign frame_done = frame_done_reg;
  assign err        = err_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed scenarios plus random traffic against a behavioural model.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       seq_valid = 1'b0;
  logic [3:0] seq_in = 4'd0;
  logic       clr_cnt = 1'b0;

  logic       locked, frame_done, err;
  logic [7:0] frame_cnt, err_cnt;
  logic       locked_s, frame_done_s, err_s;
  logic [1:0] frame_cnt_s, err_cnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequence_checker #(.LOCK_FRAMES(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .seq_valid(seq_valid), .seq_in(seq_in), .clr_cnt(clr_cnt),
    .locked(locked), .frame_done(frame_done), .err(err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  sequence_checker #(.LOCK_FRAMES(2), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .seq_valid(seq_valid), .seq_in(seq_in), .clr_cnt(clr_cnt),
    .locked(locked_s), .frame_done(frame_done_s), .err(err_s),
    .frame_cnt(frame_cnt_s), .err_cnt(err_cnt_s)
  );

  // Behavioural model: position in frame as an integer, unbounded counts saturated on compare.
  logic [3:0] frame_pat [4] = '{4'b0011, 4'b0110, 4'b0001, 4'b0100};
  bit m_track, m_locked, m_fd, m_err;
  int m_pos, m_good, m_fc, m_ec;

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  function automatic logic [18:0] exp_main();
    return {m_locked, m_fd, m_err, 8'(sat(m_fc, 255)), 8'(sat(m_ec, 255))};
  endfunction

  function automatic logic [6:0] exp_small();
    return {m_locked, m_fd, m_err, 2'(sat(m_fc, 3)), 2'(sat(m_ec, 3))};
  endfunction

  task automatic model_reset();
    m_track = 0; m_locked = 0; m_fd = 0; m_err = 0;
    m_pos = 0; m_good = 0; m_fc = 0; m_ec = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] w, input bit clr);
    m_fd = 0; m_err = 0;
    if (v) begin
      if (!m_track) begin
        if (w == frame_pat[0]) begin m_track = 1; m_pos = 1; end
      end else if (w == frame_pat[m_pos]) begin
        if (m_pos == 3) begin
          m_fd = 1; m_fc++;
          m_good = sat(m_good + 1, 2);
          if (m_good == 2) m_locked = 1;
        end
        m_pos = (m_pos + 1) % 4;
      end else begin
        m_err = 1; m_ec++; m_good = 0; m_locked = 0;
        if (w == frame_pat[0]) m_pos = 1;
        else begin m_track = 0; m_pos = 0; end
      end
    end
    if (clr) begin m_fc = 0; m_ec = 0; end
  endtask

  // Drive one cycle, advance the model at the edge, leave time at edge+1 for sampling.
  task automatic apply(input bit v, input logic [3:0] w, input bit clr);
    seq_valid = v; seq_in = w; clr_cnt = clr;
    @(posedge clk);
    model_step(v, w, clr);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    seq_valid = 1'b1; seq_in = 4'b0011;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main()) begin
      failures++;
      $display("FAIL reset: got %b exp %b", {locked, frame_done, err, frame_cnt, err_cnt}, exp_main());
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_clean_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      apply(1, frame_pat[i % 4], 0);
      checks++;
      if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main()) begin
        failures++;
        $display("FAIL clean word %0d: got %b exp %b", i + 1, {locked, frame_done, err, frame_cnt, err_cnt}, exp_main());
      end
    end
    checks++;
    if (frame_cnt !== 8'd3 || locked !== 1'b1 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clean summary: got fc=%0d lk=%b ec=%0d exp fc=3 lk=1 ec=0", frame_cnt, locked, err_cnt);
    end
    $display("clean_stream: frame_cnt=%0d locked=%b", frame_cnt, locked);
  endtask

  task automatic test_garbage();
    logic [3:0] words [6] = '{4'b1111, 4'b0000, 4'b0011, 4'b0110, 4'b0001, 4'b0100};
    do_reset();
    foreach (words[i]) begin
      apply(1, words[i], 0);
      checks++;
      if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main()) begin
        failures++;
        $display("FAIL garbage word %0d: got %b exp %b", i, {locked, frame_done, err, frame_cnt, err_cnt}, exp_main());
      end
    end
    checks++;
    if (frame_cnt !== 8'd1 || locked !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL garbage summary: got fc=%0d lk=%b ec=%0d exp fc=1 lk=0 ec=0", frame_cnt, locked, err_cnt);
    end
    $display("garbage: frame_cnt=%0d err_cnt=%0d", frame_cnt, err_cnt);
  endtask

  task automatic test_mismatch_relock();
    logic [3:0] words [19] = '{4'b0011, 4'b0110, 4'b0001, 4'b0100, 4'b0011, 4'b0110, 4'b0001, 4'b0100,
                               4'b0011, 4'b0110, 4'b0110,
                               4'b0011, 4'b0110, 4'b0001, 4'b0100, 4'b0011, 4'b0110, 4'b0001, 4'b0100};
    do_reset();
    foreach (words[i]) begin
      apply(1, words[i], 0);
      checks++;
      if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main()) begin
        failures++;
        $display("FAIL relock word %0d: got %b exp %b", i, {locked, frame_done, err, frame_cnt, err_cnt}, exp_main());
      end
      if (i == 10) begin
        checks++;
        if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 8'd1) begin
          failures++;
          $display("FAIL relock error: got err=%b lk=%b ec=%0d exp err=1 lk=0 ec=1", err, locked, err_cnt);
        end
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL relock final: got locked=%b exp 1", locked);
    end
    $display("mismatch_relock: err_cnt=%0d locked=%b", err_cnt, locked);
  endtask

  task automatic test_resync();
    logic [3:0] words [6] = '{4'b0011, 4'b0110, 4'b0011, 4'b0110, 4'b0001, 4'b0100};
    do_reset();
    foreach (words[i]) begin
      apply(1, words[i], 0);
      checks++;
      if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main()) begin
        failures++;
        $display("FAIL resync word %0d: got %b exp %b", i, {locked, frame_done, err, frame_cnt, err_cnt}, exp_main());
      end
    end
    checks++;
    if (frame_done !== 1'b1 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL resync final: got fd=%b ec=%0d exp fd=1 ec=1", frame_done, err_cnt);
    end
    $display("resync: frame_cnt=%0d err_cnt=%0d", frame_cnt, err_cnt);
  endtask

  task automatic test_valid_gaps();
    bit         vv [13] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [3:0] ww [13] = '{4'b0011, 4'b0110, 4'b1010, 4'b0011, 4'b1111, 4'b0001, 4'b0100,
                            4'b0011, 4'b0110, 4'b0001, 4'b0100, 4'b0011, 4'b0110};
    bit         cc [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    foreach (vv[i]) begin
      apply(vv[i], ww[i], cc[i]);
      checks++;
      if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main()) begin
        failures++;
        $display("FAIL gaps cycle %0d: got %b exp %b", i, {locked, frame_done, err, frame_cnt, err_cnt}, exp_main());
      end
      if (i == 10) begin
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 8'd0) begin
          failures++;
          $display("FAIL gaps clear: got fd=%b fc=%0d exp fd=1 fc=0", frame_done, frame_cnt);
        end
      end
    end
    $display("valid_gaps: frame_cnt=%0d locked=%b", frame_cnt, locked);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 22; i++) begin
      apply(1, frame_pat[i % 4], 0);
      checks++;
      if ({locked_s, frame_done_s, err_s, frame_cnt_s, err_cnt_s} !== exp_small()) begin
        failures++;
        $display("FAIL sat word %0d: got %b exp %b", i, {locked_s, frame_done_s, err_s, frame_cnt_s, err_cnt_s}, exp_small());
      end
    end
    checks++;
    if (frame_cnt_s !== 2'd3 || frame_cnt !== 8'd5) begin
      failures++;
      $display("FAIL sat count: got small=%0d wide=%0d exp small=3 wide=5", frame_cnt_s, frame_cnt);
    end
    // Mid-frame (two words into frame 6), assert reset between edges.
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({locked, frame_done, err, frame_cnt, err_cnt, locked_s, frame_done_s, err_s, frame_cnt_s, err_cnt_s} !== '0) begin
      failures++;
      $display("FAIL async reset: got %b %b exp all zero", {locked, frame_done, err, frame_cnt, err_cnt},
               {locked_s, frame_done_s, err_s, frame_cnt_s, err_cnt_s});
    end
    @(negedge clk);
    reset = 1'b0;
    // Rest of the discarded frame, then a fresh one: first word after release is processed.
    for (int i = 0; i < 6; i++) begin
      apply(1, (i < 2) ? frame_pat[i + 2] : frame_pat[i - 2], 0);
      checks++;
      if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main()) begin
        failures++;
        $display("FAIL post-reset word %0d: got %b exp %b", i, {locked, frame_done, err, frame_cnt, err_cnt}, exp_main());
      end
    end
    $display("saturation: small frame_cnt=%0d wide frame_cnt=%0d", frame_cnt_s, frame_cnt);
  endtask

  task automatic test_random();
    logic [3:0] w;
    bit v, c;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 47) == 0);
      w = ($urandom_range(0, 9) < 7) ? frame_pat[m_pos] : 4'($urandom_range(0, 15));
      apply(v, w, c);
      checks++;
      if ({locked, frame_done, err, frame_cnt, err_cnt} !== exp_main() ||
          {locked_s, frame_done_s, err_s, frame_cnt_s, err_cnt_s} !== exp_small()) begin
        failures++;
        $display("FAIL random cycle %0d: got %b/%b exp %b/%b", i, {locked, frame_done, err, frame_cnt, err_cnt},
                 {locked_s, frame_done_s, err_s, frame_cnt_s, err_cnt_s}, exp_main(), exp_small());
      end
      checks++;
      if (frame_done && err) begin
        failures++;
        $display("FAIL random exclusive pulses cycle %0d: got fd=1 err=1 exp not both", i);
      end
    end
    $display("random: frame_cnt=%0d err_cnt=%0d", frame_cnt, err_cnt);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_stream();
    test_garbage();
    test_mismatch_relock();
    test_resync();
    test_valid_gaps();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 Parameter LOCK_FRAMES, default 2, consecutive error-free frames required before lock (range 1..15).
REQ-002 Parameter CNT_W, default 8, width of frame and error counters.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 seq_valid  input  1  qualifies seq_in; word sampled only when high at the clk edge.
REQ-006 seq_in  input  4  received sequence word.
REQ-007 clr_cnt  input  1  synchronous clear of frame_cnt and err_cnt.
REQ-008 locked  output  1  checker is in lock.
REQ-009 frame_done  output  1  one-cycle pulse, a complete correct frame was received.
REQ-010 err  output  1  one-cycle pulse, a mismatch was detected in TRACK.
REQ-011 frame_cnt  output  CNT_W  count of correct frames, saturating.
REQ-012 err_cnt  output  CNT_W  count of mismatches, saturating.

Function
REQ-013 The frame SHALL be the four-word cycle 4'b0011, 4'b0110, 4'b0001, 4'b0100, indexed 0..3.
REQ-014 The FSM SHALL have two states: HUNT and TRACK, plus a 2-bit expected index exp_idx.
REQ-015 All outputs SHALL be registered; each response appears on the clk edge that samples the word.
REQ-016 With seq_valid low, state, exp_idx, counters and lock run SHALL hold; frame_done and err SHALL be 0.
REQ-017 HUNT, valid word == 4'b0011: go to TRACK, exp_idx = 1.
REQ-018 HUNT, valid word != 4'b0011: stay in HUNT; no err pulse, no counter change.
REQ-019 TRACK, valid word == frame[exp_idx]: exp_idx increments modulo 4; state stays TRACK.
REQ-020 TRACK, match with exp_idx == 3: frame_done pulses, frame_cnt increments, good-run counter increments (saturating at LOCK_FRAMES).
REQ-021 locked SHALL be 1 on the edge the good-run counter reaches LOCK_FRAMES and remain 1 until a mismatch or reset.
REQ-022 TRACK, mismatch: err pulses, err_cnt increments, good-run counter and locked clear on the same edge.
REQ-023 TRACK, mismatch where word == 4'b0011: resync; stay in TRACK with exp_idx = 1.
REQ-024 TRACK, mismatch where word != 4'b0011: go to HUNT, exp_idx = 0.
REQ-025 frame_cnt and err_cnt SHALL saturate at all-ones and not wrap.
REQ-026 clr_cnt SHALL zero both counters at the next edge, with priority over a simultaneous increment; FSM, lock and pulses are unaffected.
REQ-027 frame_done and err SHALL never be high in the same cycle.

Reset
REQ-028 On reset assertion, outputs SHALL asynchronously go to: state HUNT, exp_idx 0, good-run 0, locked 0, frame_done 0, err 0, frame_cnt 0, err_cnt 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, checking restarts in HUNT.
REQ-030 The first sampling edge after reset deassertion SHALL be processed normally.

Verification
REQ-031 Reset, then continuous valid 0011,0110,0001,0100 x3 -> frame_done pulses on words 4, 8, 12; locked=1 from word 8; frame_cnt=3; err_cnt=0.
REQ-032 Pre-stream garbage 1111,0000 then one clean frame -> no err; frame_cnt=1; locked=0.
REQ-033 Locked stream, then word 0110 where 0001 is expected -> err pulse, locked=0, err_cnt=1, state HUNT; two further clean frames -> locked=1 again.
REQ-034 In TRACK at exp_idx 2, word 0011 -> err pulse, resync; next 0110,0001,0100 -> frame_done with no second err.
REQ-035 Clean frame with seq_valid low for 3 cycles between words 2 and 3 -> frame_done on word 4, no err; then clr_cnt together with a completing word -> frame_cnt=0.
REQ-036 CNT_W=2, 5 clean frames -> frame_cnt saturates at 3; reset asserted mid-frame -> all outputs 0 immediately.
